sseg_mux_ndig: RTL and testbench
================================

// Module: sseg_mux_ndig
// PURPOSE
//  Parametrised N-digit seven-segment driver and successor to the fixed 4-digit driver.
//  - Accepts an unsigned binary value on a load strobe.
//  - Converts it to BCD sequentially with a shift-add-3 engine.
//  - Commits the result atomically to a display register.
//  - Time-multiplexes the digits onto the board anodes, with leading-zero blanking,
//    optional minus sign, decimal point and overflow dashes.
//  - Sits between counter/arith logic and the board SSEG pins.
// PARAMETERS
//  NDIG         4      number of digits driven (2..8)
//  BIN_W        14     width of binary input (1..27)
//  REFRESH_DIV  50000  clk cycles each digit stays enabled (>=2)
// PORTS
//  clk      in   1                   system clock, all logic on posedge
//  rst      in   1                   synchronous, active-high reset
//  bin      in   BIN_W               unsigned value, sampled on accepted load
//  load     in   1                   start conversion; accepted only when busy=0
//  sign     in   1                   sampled with bin; 1 = show minus on leftmost digit
//  dp_en    in   1                   1 = light decimal point of digit dp_sel (live, not latched)
//  dp_sel   in   $clog2(NDIG)        dp digit index, 0 = rightmost
//  busy     out  1                   conversion in progress
//  done     out  1                   1-cycle pulse when new value committed
//  ovf      out  1                   committed value not representable (dashes shown)
//  ssegs    out  8                   active-low {a,b,c,d,e,f,g,dp}, dp = bit0
//  disp_en  out  NDIG                active-low anodes, bit0 = rightmost digit
//  bright   in   4                   SSEG_DIM_EN only: duty in 16ths
// BEHAVIOUR
//  Reset: busy=0, done=0, ovf=0, ssegs=8'hFF, disp_en=all 1s, slot=0, refresh cnt=0,
//    display-valid=0.
//  Display-valid=0 shows 8'hFD (dash) on every digit until the first commit.
//  Engine FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
//  - IDLE: load=1 latches bin and sign, clears the BCD accumulator, sets busy, enters SHIFT.
//  - SHIFT: exactly BIN_W cycles. Each cycle, every BCD nibble >=5 gets +3, then
//    {bcd,bin} shifts left by 1.
//  - COMMIT: writes the digit register and ovf, sets display-valid, pulses done,
//    clears busy.
//  Latency: load sampled at edge 0 -> done=1 and new digits live after edge BIN_W+1.
//  load while busy is ignored, with no queueing. A new load in the COMMIT cycle is also
//  ignored; it is accepted the next cycle.
//  BCD accumulator width is 4*NDIG+4 bits. ovf=1 if value >= 10**NDIG, or if sign=1 and
//  value >= 10**(NDIG-1). ovf forces all digits to dash.
//  Blanking: digit k (k>0) shows OFF (8'hFF) if value < 10**k. Digit 0 is never blanked.
//    Sign=1 overrides the leftmost digit with dash.
//  Multiplex:
//  - Refresh counter wraps at REFRESH_DIV-1. On wrap, slot increments and wraps NDIG-1 -> 0.
//  - ssegs and disp_en are registered from slot, giving 1-cycle lag. Exactly one disp_en
//    bit is low.
//  - dp applies to any digit, blanked or dashed: ssegs[0] = ~(dp_en && dp_sel==slot).
//    dp_sel >= NDIG lights nothing.
//  Reset mid-conversion aborts the conversion and returns to the reset state. No done pulse.
//  Segment codes 0-9: 03 9F 25 0D 99 49 41 1F 01 09.
// CONFIGURATION
//  SSEG_DIM_EN defined:
//  - Adds the bright port.
//  - Within each slot, the digit's disp_en bit is low only while
//    refresh_cnt < (bright*REFRESH_DIV)/16. Other cycles are all-off.
//  - bright=0 gives a dark display; bright=15 gives 15/16 duty.
//  SSEG_DIM_EN undefined: no bright port; 100% duty.
// STRUCTURE
//  Package sseg_pkg:
//  - constants SEG_DASH=8'hFD and SEG_OFF=8'hFF
//  - function seg_decode(logic [3:0]) -> logic [7:0]
//  - typedef eng_state_t {IDLE,SHIFT,COMMIT}
//  Sub-module bin2bcd_seq #(BIN_W,NDIG): the shift-add-3 engine with start/busy/done,
//    bcd and ovf outputs. The top holds the multiplexer and blanking.
// TESTING  (NDIG=4, BIN_W=14, REFRESH_DIV=4)
//  1. Reset 3 cycles -> ssegs=FF, disp_en=1111; then each slot shows FD with one anode low.
//  2. load bin=1234 -> done at edge 15, ovf=0; digits 3..0 = 9F,25,0D,99.
//  3. load bin=7, sign=1 -> digit3=FD, digits 2,1=FF, digit0=1F.
//  4. load bin=12000 -> ovf=1, all digits FD. Then bin=1234 with sign=1 -> ovf=1.
//  5. load 0, then pulse load 5 cycles later while busy -> one done only; digit0=03,
//     others FF.
//  6. dp_en=1, dp_sel=2 with value 5 -> digit2 ssegs=FE; rst asserted mid-SHIFT -> no done,
//     dashes shown.
//  Macro: SSEG_DIM_EN with REFRESH_DIV=16, bright=4 -> each anode low 4 of every 16 slot
//    cycles.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants, segment decoder and engine state type for the seven-segment driver.
package sseg_pkg;

  localparam logic [7:0] SEG_DASH = 8'hFD;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} eng_state_t;

  // Active-low {a,b,c,d,e,f,g,dp}; dp left dark, callers overlay it.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD engine; commits digits, sign and overflow atomically.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int unsigned BIN_W = 14,
  parameter int unsigned NDIG  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  input  logic              sign,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [4*NDIG-1:0] bcd,
  output logic              ovf,
  output logic              neg
);

  localparam int unsigned ACC_W = 4 * NDIG + 4;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIM_POS = pow10(NDIG);
  localparam longint unsigned LIM_NEG = pow10(NDIG - 1);

  eng_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_adj;
  logic             sign_acc_q, sign_acc_d;
  logic             ovf_acc_q, ovf_acc_d;

  logic [4*NDIG-1:0] bcd_q;
  logic              ovf_q, neg_q, valid_q, done_q;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i <= int'(NDIG); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    sign_acc_d = sign_acc_q;
    ovf_acc_d  = ovf_acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = bin;
          acc_d      = '0;
          cnt_d      = '0;
          sign_acc_d = sign;
          ovf_acc_d  = (64'(bin) >= LIM_POS) || (sign && (64'(bin) >= LIM_NEG));
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = {acc_adj[ACC_W-2:0], shreg_q[BIN_W-1]};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // A bit falling off the accumulator can only mean an out-of-range value.
        ovf_acc_d = ovf_acc_q | acc_adj[ACC_W-1];
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      acc_q      <= '0;
      sign_acc_q <= 1'b0;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      sign_acc_q <= sign_acc_d;
      ovf_acc_q  <= ovf_acc_d;
      done_q     <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        bcd_q   <= acc_q[4*NDIG-1:0];
        ovf_q   <= ovf_acc_q;
        neg_q   <= sign_acc_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign valid = valid_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
  assign neg   = neg_q;

endmodule

// File: rtl/sseg_mux_ndig.sv
// N-digit multiplexed seven-segment driver with blanking, sign, dp and overflow dashes.
// Optional SSEG_DIM_EN adds a 'bright' port for 16-step duty dimming of each digit slot.
module sseg_mux_ndig
  import sseg_pkg::*;
#(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_W-1:0]        bin,
  input  logic                    load,
  input  logic                    sign,
  input  logic                    dp_en,
  input  logic [$clog2(NDIG)-1:0] dp_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [7:0]              ssegs,
  output logic [NDIG-1:0]         disp_en
`ifdef SSEG_DIM_EN
  ,
  input  logic [3:0]              bright
`endif
);

  localparam int unsigned SW = $clog2(NDIG);
  localparam int unsigned RW = $clog2(REFRESH_DIV);

  logic [4*NDIG-1:0] bcd;
  logic              valid, neg;

  bin2bcd_seq #(
    .BIN_W(BIN_W),
    .NDIG (NDIG)
  ) u_eng (
    .clk  (clk),
    .rst  (rst),
    .start(load),
    .bin  (bin),
    .sign (sign),
    .busy (busy),
    .done (done),
    .valid(valid),
    .bcd  (bcd),
    .ovf  (ovf),
    .neg  (neg)
  );

  logic [RW-1:0]   ref_q, ref_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [7:0]      ssegs_q, ssegs_d;
  logic [NDIG-1:0] disp_en_q, disp_en_d;
  logic [NDIG-1:0] blank;
  logic            nz, wrap;

  // Digit k is blank when it and every digit to its left are zero.
  always_comb begin
    nz    = 1'b0;
    blank = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      nz       = nz | (bcd[4*k +: 4] != 4'd0);
      blank[k] = ~nz;
    end
  end

  always_comb begin
    wrap   = (ref_q == RW'(REFRESH_DIV - 1));
    ref_d  = wrap ? '0 : ref_q + RW'(1);
    slot_d = slot_q;
    if (wrap) slot_d = (slot_q == SW'(NDIG - 1)) ? '0 : slot_q + SW'(1);

    if (!valid || ovf) begin
      ssegs_d = SEG_DASH;
    end else if (neg && (slot_q == SW'(NDIG - 1))) begin
      ssegs_d = SEG_DASH;
    end else if ((slot_q != '0) && blank[slot_q]) begin
      ssegs_d = SEG_OFF;
    end else begin
      ssegs_d = seg_decode(bcd[{slot_q, 2'b00} +: 4]);
    end
    ssegs_d[0] = ~(dp_en && (dp_sel == slot_q));
    disp_en_d  = ~({{(NDIG-1){1'b0}}, 1'b1} << slot_q);
`ifdef SSEG_DIM_EN
    if (32'(ref_q) >= ((32'(bright) * REFRESH_DIV) >> 4)) begin
      ssegs_d   = SEG_OFF;
      disp_en_d = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q     <= '0;
      slot_q    <= '0;
      ssegs_q   <= SEG_OFF;
      disp_en_q <= '1;
    end else begin
      ref_q     <= ref_d;
      slot_q    <= slot_d;
      ssegs_q   <= ssegs_d;
      disp_en_q <= disp_en_d;
    end
  end

  assign ssegs   = ssegs_q;
  assign disp_en = disp_en_q;

endmodule

// File: tb/tb_sseg_mux_ndig.sv
// Scoreboard bench for sseg_mux_ndig: loads push expected displays, a monitor checks on done.
module tb_sseg_mux_ndig;

  localparam int NDIG  = 4;
  localparam int BIN_W = 14;
  localparam int RD    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        sign = 1'b0;
  logic        dp_en = 1'b0;
  logic [13:0] bin = '0;
  logic [1:0]  dp_sel = '0;
  logic        busy, done, ovf;
  logic [7:0]  ssegs;
  logic [3:0]  disp_en;
`ifdef SSEG_DIM_EN
  logic [3:0]  bright = 4'd15;
`endif

  sseg_mux_ndig #(
    .NDIG       (NDIG),
    .BIN_W      (BIN_W),
    .REFRESH_DIV(RD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bin    (bin),
    .load   (load),
    .sign   (sign),
    .dp_en  (dp_en),
    .dp_sel (dp_sel),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .ssegs  (ssegs),
    .disp_en(disp_en)
`ifdef SSEG_DIM_EN
    ,
    .bright (bright)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int               t_done;
    bit               ovf;
    logic [3:0][7:0]  codes;
  } exp_t;

  exp_t q[$];
  bit   scanning = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: digits by decimal division, rules straight from the display description.
  function automatic logic [3:0][7:0] model(input int v, input bit s, input bit de,
                                            input int ds, output bit o);
    logic [7:0] tbl [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    logic [3:0][7:0] c;
    int p;
    o = (v >= 10000) || (s && v >= 1000);
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      if (o)                  c[k] = 8'hFD;
      else if (s && k == 3)   c[k] = 8'hFD;
      else if (k > 0 && v < p) c[k] = 8'hFF;
      else                    c[k] = tbl[(v / p) % 10];
      if (de && ds == k) c[k] = c[k] & 8'hFE;
      p = p * 10;
    end
    return c;
  endfunction

  function automatic logic [3:0][7:0] dashes(input bit de, input int ds);
    logic [3:0][7:0] c;
    for (int k = 0; k < NDIG; k++) begin
      c[k] = 8'hFD;
      if (de && ds == k) c[k] = 8'hFC;
    end
    return c;
  endfunction

  // Watch the multiplexer until every anode has been seen once.
  task automatic scan(input string name, input logic [3:0][7:0] exp);
    bit [3:0] seen = '0;
    int idx;
    for (int i = 0; i < 3 * NDIG * RD && seen != 4'hF; i++) begin
      @(negedge clk);
`ifdef SSEG_DIM_EN
      check({name, "_anodes"}, 32'($countones(~disp_en) > 1), 32'd0);
`else
      check({name, "_anodes"}, 32'($countones(~disp_en)), 32'd1);
`endif
      if ($countones(~disp_en) == 1) begin
        idx = 0;
        for (int k = 0; k < NDIG; k++) if (!disp_en[k]) idx = k;
        if (!seen[idx]) begin
          check($sformatf("%s_dig%0d", name, idx), 32'(ssegs), 32'(exp[idx]));
          seen[idx] = 1'b1;
        end
      end
    end
    if (seen != 4'hF) check({name, "_scan_timeout"}, 32'(seen), 32'hF);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          scanning = 1'b1;
          e = q[0];
          check("done_cycle", 32'(cyc), 32'(e.t_done));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("busy_at_done", 32'(busy), 32'd0);
          @(negedge clk);
          check("done_pulse", 32'(done), 32'd0);
          scan("value", e.codes);
          void'(q.pop_front());
          scanning = 1'b0;
        end
      end
    end
  end

  task automatic do_load(input int v, input bit s, input bit de, input int ds);
    exp_t e;
    bit o;
    @(negedge clk);
    bin    = 14'(v);
    sign   = s;
    dp_en  = de;
    dp_sel = 2'(ds);
    load   = 1'b1;
    e.codes  = model(v, s, de, ds, o);
    e.ovf    = o;
    e.t_done = cyc + BIN_W + 2;
    q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    check("busy_after_load", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q.size() != 0 || scanning); i++) @(negedge clk);
    if (q.size() != 0 || scanning) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "scoreboard stalled");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ssegs", 32'(ssegs), 32'hFF);
    check("rst_disp_en", 32'(disp_en), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    scan("reset_dash", dashes(1'b0, 0));

    do_load(1234, 1'b0, 1'b0, 0);  drain();
    do_load(7, 1'b1, 1'b0, 0);     drain();
    do_load(12000, 1'b0, 1'b0, 0); drain();
    do_load(1234, 1'b1, 1'b0, 0);  drain();

    // Load while busy must be dropped.
    do_load(0, 1'b0, 1'b0, 0);
    repeat (4) @(negedge clk);
    bin  = 14'd999;
    load = 1'b1;
    check("busy_ignored_load", 32'(busy), 32'd1);
    @(negedge clk);
    load = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    do_load(5, 1'b0, 1'b1, 2); drain();

    // Reset in the middle of a conversion: no done, back to dashes.
    @(negedge clk);
    bin  = 14'd5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    scan("abort_dash", dashes(1'b1, 2));

    for (int i = 0; i < 12; i++) begin
      do_load(int'($urandom_range(0, 16383)), ($urandom % 4) == 0, $urandom % 2,
              int'($urandom % 4));
      drain();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
